fp_sub_iter: RTL and testbench

FP_SUB_ITER -- requirements
Module: fp_sub_iter

---
 rtl/fp_sub_pkg.sv | 7 +
 rtl/fp_align_shift.sv | 10 +
 rtl/fp_sub_iter.sv | 100 ++++++++++
 tb/tb_fp_sub_iter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fp_sub_pkg.sv
// fp_sub_pkg: FSM states and single-precision field widths shared by fp_sub_iter.
package fp_sub_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
  typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, DONE} state_t;
endpackage

// File: rtl/fp_align_shift.sv
// fp_align_shift: one-cycle mantissa right shifter, saturating to zero at 24 or more.
module fp_align_shift
  import fp_sub_pkg::*;
(
  input  logic [FRAC_W:0]  val,
  input  logic [EXP_W-1:0] sh,
  output logic [FRAC_W:0]  res
);
  assign res = (sh >= 8'(FRAC_W + 1)) ? '0 : val >> sh;
endmodule

// File: rtl/fp_sub_iter.sv
// fp_sub_iter: iterative IEEE-754 single subtractor (a - b), truncating, no subnormals.
module fp_sub_iter
  import fp_sub_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff
);
  state_t state, state_nx;
  logic [31:0] a_r, b_r, diff_r, zero_res;
  logic sign_r, add_r, a_big, zero_in, carry, low, ovf, unf;
  logic [EXP_W-1:0] exp_r;
  logic [FRAC_W:0] mh_r, ml_r, ml_sh;
  logic [FRAC_W+1:0] m_r, sum;
  logic [30:0] hi, lo;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign diff = diff_r;
  assign zero_in = a[30:0] == '0 || b[30:0] == '0;
  assign zero_res = a[30:0] == '0 ? {~b[31], b[30:0]} : a;
  // b_r already carries the inverted sign, so both operands are added terms
  assign a_big = a_r[30:0] >= b_r[30:0];
  assign hi = a_big ? a_r[30:0] : b_r[30:0];
  assign lo = a_big ? b_r[30:0] : a_r[30:0];
  fp_align_shift u_shift (
    .val({1'b1, lo[FRAC_W-1:0]}),
    .sh(hi[30:FRAC_W] - lo[30:FRAC_W]),
    .res(ml_sh)
  );
  assign sum = add_r ? {1'b0, mh_r} + {1'b0, ml_r} : {1'b0, mh_r} - {1'b0, ml_r};
  assign ovf = exp_r == EXP_MAX;
  assign unf = exp_r == '0;
  assign carry = m_r[FRAC_W+1];
  assign low = !m_r[FRAC_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? (zero_in ? DONE : ALIGN) : IDLE;
      ALIGN:   state_nx = ADDSUB;
      ADDSUB:  state_nx = sum == '0 ? DONE : NORM;
      NORM:    state_nx = (ovf || unf || !(carry || low)) ? DONE : NORM;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      diff_r <= '0;
      sign_r <= 1'b0;
      add_r <= 1'b0;
      exp_r <= '0;
      mh_r <= '0;
      ml_r <= '0;
      m_r <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= {~b[31], b[30:0]};
          if (zero_in) diff_r <= zero_res;
        end
        ALIGN: begin
          sign_r <= a_big ? a_r[31] : b_r[31];
          add_r <= a_r[31] == b_r[31];
          exp_r <= hi[30:FRAC_W];
          mh_r <= {1'b1, hi[FRAC_W-1:0]};
          ml_r <= ml_sh;
        end
        ADDSUB: begin
          m_r <= sum;
          if (sum == '0) diff_r <= '0;
        end
        // exponent limits are checked one cycle after the shift that reached them
        NORM: begin
          if (ovf) diff_r <= {sign_r, EXP_MAX, {FRAC_W{1'b0}}};
          else if (unf) diff_r <= '0;
          else if (carry) begin
            m_r <= m_r >> 1;
            exp_r <= exp_r + 1'b1;
          end else if (low) begin
            m_r <= m_r << 1;
            exp_r <= exp_r - 1'b1;
          end else diff_r <= {sign_r, exp_r, m_r[FRAC_W-1:0]};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_sub_iter.sv
// tb_fp_sub_iter: directed vector table, handshake corner sequences and random ops vs a truncating model.
module tb_fp_sub_iter;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, diff;
  int checks = 0;
  int errors = 0;

  fp_sub_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .diff(diff)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] d;
    int lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: exact truncating subtraction from field values, leading-one normalisation.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] d, output int lat);
    logic [31:0] ny, hi, lo;
    longint mh, ml, r;
    int eh, el, p, e;
    if (x[30:0] == 0) begin d = {~y[31], y[30:0]}; lat = 1; return; end
    if (y[30:0] == 0) begin d = x; lat = 1; return; end
    ny = {~y[31], y[30:0]};
    if (x[30:0] >= ny[30:0]) begin hi = x; lo = ny; end
    else begin hi = ny; lo = x; end
    eh = int'(hi[30:23]);
    el = int'(lo[30:23]);
    mh = longint'({1'b1, hi[22:0]});
    ml = longint'({1'b1, lo[22:0]});
    ml = (eh - el >= 24) ? 0 : ml >> (eh - el);
    r = (x[31] == ny[31]) ? mh + ml : mh - ml;
    if (r == 0) begin d = 0; lat = 3; return; end
    p = 24;
    while (!r[p]) p--;
    e = eh + p - 23;
    if (p == 24) begin
      lat = 5;
      d = (e >= 255) ? {hi[31], 8'hFF, 23'h0} : {hi[31], 8'(e), 23'(r >> 1)};
    end else if (e <= 0) begin
      lat = 4 + eh;
      d = 0;
    end else begin
      lat = 4 + 23 - p;
      d = {hi[31], 8'(e), 23'(r << (23 - p))};
    end
  endfunction

  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit ovl);
    lat = 1;
    ovl = 1'b0;
    while (!out_valid && lat < 40) begin
      ovl |= in_ready;
      @(negedge clk);
      lat++;
    end
    ovl |= in_ready && out_valid;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] d_exp, input int lat_exp);
    int lat;
    bit ovl;
    start_op(x, y);
    wait_done(lat, ovl);
    chk($sformatf("%s diff a=%h b=%h", tag, x, y), diff, d_exp);
    chk($sformatf("%s latency a=%h b=%h", tag, x, y), 32'(lat), 32'(lat_exp));
    chk($sformatf("%s ready/valid overlap", tag), {31'b0, ovl}, 32'd0);
    finish_op();
  endtask

  vec_t tbl[12];

  initial begin
    int lat;
    bit ovl;
    logic [31:0] x, y, d_exp;
    int lat_exp, ea, eb;
    tbl[0]  = '{32'h41000000, 32'h40E00000, 32'h3F800000, 7};
    tbl[1]  = '{32'h3FE00000, 32'hC2A22000, 32'h42A5A000, 4};
    tbl[2]  = '{32'h40000000, 32'hC0000000, 32'h40800000, 5};
    tbl[3]  = '{32'h41200000, 32'h41200000, 32'h00000000, 3};
    tbl[4]  = '{32'h00000000, 32'h3F800000, 32'hBF800000, 1};
    tbl[5]  = '{32'h3F800000, 32'h00000000, 32'h3F800000, 1};
    tbl[6]  = '{32'h00000000, 32'h00000000, 32'h80000000, 1};
    tbl[7]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 5};
    tbl[8]  = '{32'h00800001, 32'h00800000, 32'h00000000, 5};
    tbl[9]  = '{32'h3F800000, 32'h4B800000, 32'hCB800000, 4};
    tbl[10] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 5};
    tbl[11] = '{32'hC0400000, 32'h3F800000, 32'hC0800000, 5};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset diff", diff, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_check($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].d, tbl[i].lat);

    // Consumer stalls: result and handshake must hold
    start_op(32'h41000000, 32'h40E00000);
    wait_done(lat, ovl);
    chk("stall latency", 32'(lat), 32'd7);
    for (int i = 0; i < 10; i++) begin
      chk("stall diff", diff, 32'h3F800000);
      chk("stall in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall out_valid", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
    end
    finish_op();
    chk("after stall in_ready", {31'b0, in_ready}, 32'd1);

    // Asynchronous reset while normalising
    start_op(32'h41000000, 32'h40E00000);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midnorm reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("midnorm reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("midnorm reset diff", diff, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post reset no result", {31'b0, out_valid}, 32'd0);
    end
    run_check("post reset", 32'h3FE00000, 32'hC2A22000, 32'h42A5A000, 4);

    for (int i = 0; i < 300; i++) begin
      ea = int'($urandom_range(1, 254));
      if ($urandom_range(0, 1) == 1) begin
        eb = ea + int'($urandom_range(0, 6)) - 3;
        eb = eb < 1 ? 1 : (eb > 254 ? 254 : eb);
      end else eb = int'($urandom_range(1, 254));
      x = {1'($urandom), 8'(ea), 23'($urandom)};
      y = {1'($urandom), 8'(eb), 23'($urandom)};
      if ($urandom_range(0, 15) == 0) y = x;
      else if ($urandom_range(0, 15) == 0) y = {~x[31], x[30:0]};
      model(x, y, d_exp, lat_exp);
      run_check("rand", x, y, d_exp, lat_exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
